// File: rtl/dp_pkg.sv
// Shared data-plane types: default field widths and the {dest, payload} packet layout.
package dp_pkg;

   localparam int DP_ID_W   = 16;
   localparam int DP_DATA_W = 16;

   typedef struct packed {
      logic [DP_ID_W-1:0]   dest;
      logic [DP_DATA_W-1:0] payload;
   } dp_packet_t;

endpackage

// File: rtl/rx_ram_2p.sv
// Simple dual-port RAM: one write port, one registered read port on the same clock.
// The read register resets to zero and holds its value when no read is issued.
module rx_ram_2p #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_plane_rx_fifo.sv
// Receive buffer: filters packets by destination ID into a circular FIFO, pulses a flag per
// MSG_LEN accepted words, and lets the GPP pop words in order with one cycle of read latency.
module data_plane_rx_fifo
   import dp_pkg::*;
#(
   parameter int ID_W    = DP_ID_W,
   parameter int DATA_W  = DP_DATA_W,
   parameter int DEPTH   = 16,
   parameter int MSG_LEN = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ID_W+DATA_W-1:0]   data_rx_packet,
   input  logic                     data_rx_valid,
   input  logic [ID_W-1:0]          node_id,
   input  logic                     gpp_rtr_dp,
   output logic [DATA_W-1:0]        RAM_rx_data_out,
   output logic                     rx_data_out_valid,
   output logic                     data_rx_complete_flag,
   output logic                     rx_full,
   output logic                     rx_empty,
   output logic [$clog2(DEPTH):0]   rx_level,
   output logic                     rx_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam logic [CW-1:0] MSG_LAST = CW'(MSG_LEN - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [CW-1:0] msg_q, msg_d;
   logic          flag_q, flag_d;
   logic          full_q, empty_q, ovf_q, ovf_d, valid_q;
   logic          match, accept, drop, pop;

   // Full/empty are registered, so a pop on an empty FIFO never reads through a same-cycle write.
   assign match  = data_rx_valid && (data_rx_packet[ID_W+DATA_W-1:DATA_W] == node_id);
   assign accept = match && !full_q;
   assign drop   = match && full_q;
   assign pop    = gpp_rtr_dp && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      msg_d    = msg_q;
      flag_d   = 1'b0;
      ovf_d    = ovf_q | drop;
      if (accept) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (accept && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!accept && pop) begin
         level_d = level_q - LW'(1);
      end
      if (accept) begin
         if (msg_q == MSG_LAST) begin
            msg_d  = '0;
            flag_d = 1'b1;
         end else begin
            msg_d = msg_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         msg_q    <= '0;
         flag_q   <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         msg_q    <= msg_d;
         flag_q   <= flag_d;
         full_q   <= (level_d == LVL_FULL);
         empty_q  <= (level_d == '0);
         ovf_q    <= ovf_d;
         valid_q  <= pop;
      end
   end

   rx_ram_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (accept),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_rx_packet[DATA_W-1:0]),
      .re_i    (pop),
      .raddr_i (rd_ptr_q),
      .rdata_o (RAM_rx_data_out)
   );

   assign rx_data_out_valid     = valid_q;
   assign data_rx_complete_flag = flag_q;
   assign rx_full               = full_q;
   assign rx_empty              = empty_q;
   assign rx_level              = level_q;
   assign rx_overflow           = ovf_q;

endmodule

// File: tb/tb_data_plane_rx_fifo.sv
// Directed bench: an 8-deep instance (a_*) for filtering, messages, pops, wrap and reset,
// and a 4-deep instance (b_*) for full/overflow handling.
module tb_data_plane_rx_fifo;
   import dp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] node_id;

   logic [31:0] a_pkt, b_pkt;
   logic        a_vld, b_vld, a_rd, b_rd;
   logic [15:0] a_dout, b_dout;
   logic        a_dvld, b_dvld, a_flag, b_flag, a_full, b_full, a_empty, b_empty;
   logic        a_ovf, b_ovf;
   logic [3:0]  a_level;
   logic [2:0]  b_level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_plane_rx_fifo #(.ID_W(16), .DATA_W(16), .DEPTH(8), .MSG_LEN(5)) dut_a (
      .clk(clk), .rst(rst), .data_rx_packet(a_pkt), .data_rx_valid(a_vld), .node_id(node_id),
      .gpp_rtr_dp(a_rd), .RAM_rx_data_out(a_dout), .rx_data_out_valid(a_dvld),
      .data_rx_complete_flag(a_flag), .rx_full(a_full), .rx_empty(a_empty),
      .rx_level(a_level), .rx_overflow(a_ovf)
   );

   data_plane_rx_fifo #(.ID_W(16), .DATA_W(16), .DEPTH(4), .MSG_LEN(5)) dut_b (
      .clk(clk), .rst(rst), .data_rx_packet(b_pkt), .data_rx_valid(b_vld), .node_id(node_id),
      .gpp_rtr_dp(b_rd), .RAM_rx_data_out(b_dout), .rx_data_out_valid(b_dvld),
      .data_rx_complete_flag(b_flag), .rx_full(b_full), .rx_empty(b_empty),
      .rx_level(b_level), .rx_overflow(b_ovf)
   );

   function automatic dp_packet_t mk(input logic [15:0] dest, input logic [15:0] payload);
      dp_packet_t p;
      p.dest    = dest;
      p.payload = payload;
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled at that same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] exp_q [$];
      rst = 1'b1; node_id = 16'h0003;
      a_pkt = '0; a_vld = 0; a_rd = 0;
      b_pkt = '0; b_vld = 0; b_rd = 0;

      // Reset state
      tick(); tick();
      check("rst_empty", a_empty, 1);
      check("rst_full", a_full, 0);
      check("rst_level", a_level, 0);
      check("rst_ovf", a_ovf, 0);
      check("rst_dvld", a_dvld, 0);
      check("rst_flag", a_flag, 0);
      check("rst_dout", a_dout, 0);
      check("rst_b_empty", b_empty, 1);
      rst = 1'b0;

      // DEPTH=4: six matching packets, last two dropped, no completion pulse
      for (int i = 0; i < 6; i++) begin
         b_vld = 1; b_pkt = mk(16'h0003, 16'hE000 + 16'(i));
         tick();
         check("b_fill_level", b_level, (i < 4) ? i + 1 : 4);
         check("b_fill_full", b_full, (i >= 3) ? 1 : 0);
         check("b_fill_ovf", b_ovf, (i >= 4) ? 1 : 0);
         check("b_fill_flag", b_flag, 0);
      end
      // Write while full with a simultaneous pop: write dropped, pop happens
      b_vld = 1; b_rd = 1; b_pkt = mk(16'h0003, 16'hE009);
      tick();
      check("b_fullpop_dvld", b_dvld, 1);
      check("b_fullpop_dout", b_dout, 16'hE000);
      check("b_fullpop_level", b_level, 3);
      check("b_fullpop_ovf", b_ovf, 1);
      b_vld = 0;
      for (int i = 1; i < 4; i++) begin
         tick();
         check("b_drain_dout", b_dout, 16'hE000 + 16'(i));
      end
      b_rd = 0;
      tick();
      check("b_drain_empty", b_empty, 1);
      check("b_drain_dvld", b_dvld, 0);
      check("b_ovf_sticky", b_ovf, 1);

      // Five matching packets interleaved with foreign-ID packets
      for (int i = 0; i < 5; i++) begin
         a_vld = 1; a_pkt = mk(16'h0003, 16'hA000 + 16'(i));
         tick();
         check("msg_flag", a_flag, (i == 4) ? 1 : 0);
         a_pkt = mk(16'h0007, 16'hBEEF);
         tick();
         check("foreign_flag", a_flag, 0);
         check("foreign_level", a_level, i + 1);
      end
      a_vld = 0; a_pkt = mk(16'h0003, 16'hDEAD);
      tick();
      check("invalid_level", a_level, 5);
      check("a_ovf_clear", a_ovf, 0);

      // Pop five with the request held, then one pop on empty
      a_rd = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("pop_dvld", a_dvld, 1);
         check("pop_dout", a_dout, 16'hA000 + 16'(i));
      end
      tick();
      check("pop_empty_dvld", a_dvld, 0);
      check("pop_empty_hold", a_dout, 16'hA004);
      check("pop_empty_flag", a_empty, 1);
      check("pop_empty_level", a_level, 0);
      a_rd = 0;

      // Fill to 3, then accept and pop every cycle; pointers wrap past 8
      for (int i = 0; i < 3; i++) begin
         a_vld = 1; a_pkt = mk(16'h0003, 16'hB000 + 16'(i));
         exp_q.push_back(16'hB000 + 16'(i));
         tick();
      end
      check("stream_prefill", a_level, 3);
      a_rd = 1;
      for (int i = 0; i < 10; i++) begin
         logic [15:0] e;
         a_pkt = mk(16'h0003, 16'hC000 + 16'(i));
         exp_q.push_back(16'hC000 + 16'(i));
         e = exp_q.pop_front();
         tick();
         check("stream_level", a_level, 3);
         check("stream_dout", a_dout, e);
         check("stream_flag", a_flag, (i == 1 || i == 6) ? 1 : 0);
      end
      a_vld = 0; a_rd = 0;
      tick();

      // Reset mid-message (3 words into the count, 3 words buffered)
      rst = 1;
      tick();
      rst = 0;
      check("midrst_level", a_level, 0);
      check("midrst_empty", a_empty, 1);
      check("midrst_dout", a_dout, 0);
      check("midrst_b_ovf", b_ovf, 0);
      for (int i = 0; i < 5; i++) begin
         a_vld = 1; a_pkt = mk(16'h0003, 16'hD000 + 16'(i));
         tick();
         check("midrst_flag", a_flag, (i == 4) ? 1 : 0);
      end
      a_vld = 0; a_rd = 1;
      tick();
      check("midrst_flag_end", a_flag, 0);
      check("midrst_first", a_dout, 16'hD000);
      for (int i = 1; i < 5; i++) begin
         tick();
         check("midrst_dout_seq", a_dout, 16'hD000 + 16'(i));
      end
      a_rd = 0;
      tick();
      check("midrst_final_empty", a_empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
